// File: rtl/keypad_scan_reader.sv
// 4x4 matrix keypad reader: row scan, frame debounce, key-code FIFO, STATUS/DATA read port.
// Optional `define KEYPAD_IRQ_EN adds a registered irq output (irq = FIFO not empty).
module keypad_scan_reader #(
  parameter int          SCAN_DIV   = 50000,
  parameter int          DEBOUNCE   = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_col,
  output logic [3:0]  key_row,
  input  logic        mem_la_read,
  input  logic [31:0] mem_la_addr,
  output logic [31:0] rdata,
  output logic        rdata_sel
`ifdef KEYPAD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] FULL_CNT  = PW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE);
  localparam logic          ONE_SHOT  = (DEBOUNCE == 1);
  localparam logic [31:0]   DATA_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  logic [3:0]    r_col_meta, r_col_sync;
  logic [DW-1:0] r_div;
  logic [1:0]    r_row;
  logic [3:0]    r_key_row;
  logic          r_acc_hit;
  logic [3:0]    r_acc_code;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]    r_code, w_code_nxt;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_ovf;

  logic          w_slot_end, w_frame_end, w_row_hit, w_frame_hit, w_push;
  logic [1:0]    w_row_col;
  logic [3:0]    w_frame_code, w_cnt_field;
  logic [PW-1:0] w_count;
  logic          w_empty, w_full, w_rd_status, w_rd_data, w_pop, w_wr_en, w_drop;
  logic [31:0]   w_status_word, w_data_word;

  assign key_row = r_key_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
    end else begin
      r_col_meta <= key_col;
      r_col_sync <= r_col_meta;
    end
  end

  always_comb begin
    w_slot_end  = (r_div == DIV_LAST);
    w_frame_end = w_slot_end && (r_row == 2'd3);
    w_row_hit   = ~&r_col_sync;
    if (!r_col_sync[0])      w_row_col = 2'd0;
    else if (!r_col_sync[1]) w_row_col = 2'd1;
    else if (!r_col_sync[2]) w_row_col = 2'd2;
    else                     w_row_col = 2'd3;
    w_frame_hit  = r_acc_hit | w_row_hit;
    w_frame_code = r_acc_hit ? r_acc_code : {r_row, w_row_col};
  end

  // Row 0 restarts the frame; later rows only fill in if nothing lower was pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div      <= '0;
      r_row      <= 2'd0;
      r_key_row  <= 4'b1110;
      r_acc_hit  <= 1'b0;
      r_acc_code <= 4'd0;
    end else if (w_slot_end) begin
      r_div     <= '0;
      r_row     <= r_row + 2'd1;
      r_key_row <= {r_key_row[2:0], r_key_row[3]};
      if ((r_row == 2'd0) || !r_acc_hit) begin
        r_acc_hit  <= w_row_hit;
        r_acc_code <= {r_row, w_row_col};
      end
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SCAN;
      r_cnt   <= '0;
      r_code  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_cnt_inc   = r_cnt + CNT_ONE;
    if (w_frame_end) begin
      case (r_state)
        ST_SCAN: begin
          if (w_frame_hit) begin
            w_code_nxt  = w_frame_code;
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = ONE_SHOT ? ST_HELD : ST_CONFIRM;
          end else begin
            w_state_nxt = ST_SCAN;
          end
        end
        ST_CONFIRM: begin
          if (w_frame_hit && (w_frame_code == r_code)) begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc == CNT_MAX) ? ST_HELD : ST_CONFIRM;
          end else begin
            w_state_nxt = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (!w_frame_hit) begin
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = ONE_SHOT ? ST_SCAN : ST_RELEASE;
          end else begin
            w_state_nxt = ST_HELD;
          end
        end
        ST_RELEASE: begin
          if (!w_frame_hit) begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc == CNT_MAX) ? ST_SCAN : ST_RELEASE;
          end else begin
            w_state_nxt = ST_HELD;
          end
        end
        default: w_state_nxt = ST_SCAN;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  always_comb begin
    w_push = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        ST_SCAN:    w_push = w_frame_hit && ONE_SHOT;
        ST_CONFIRM: w_push = w_frame_hit && (w_frame_code == r_code) && (w_cnt_inc == CNT_MAX);
        default:    w_push = 1'b0;
      endcase
    end else begin
      w_push = 1'b0;
    end
  end

  // STATUS layout: overflow at bit 15, empty bit 5, full bit 4, count in bits 3:0.
  always_comb begin
    w_count       = r_wr_ptr - r_rd_ptr;
    w_empty       = (w_count == '0);
    w_full        = (w_count == FULL_CNT);
    w_cnt_field   = 4'(w_count);
    w_rd_status   = mem_la_read && (mem_la_addr == BASE_ADDR);
    w_rd_data     = mem_la_read && (mem_la_addr == DATA_ADDR);
    w_pop         = w_rd_data && !w_empty;
    w_wr_en       = w_push && (!w_full || w_pop);
    w_drop        = w_push && w_full && !w_pop;
    w_status_word = {16'h0000, r_ovf, 9'h000, w_empty, w_full, w_cnt_field};
    w_data_word   = w_empty ? 32'h0000_0000 : {1'b1, 27'h000_0000, r_mem[r_rd_ptr[AW-1:0]]};
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_frame_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ovf     <= 1'b0;
      rdata     <= 32'h0000_0000;
      rdata_sel <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_drop)           r_ovf <= 1'b1;
      else if (w_rd_status) r_ovf <= 1'b0;
      if (w_rd_status)    rdata <= w_status_word;
      else if (w_rd_data) rdata <= w_data_word;
      rdata_sel <= w_rd_status | w_rd_data;
    end
  end

`ifdef KEYPAD_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= ~w_empty;
  end
`endif

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Bench for keypad_scan_reader: directed vector table, reset/irq sequences, randomized frames vs. a frame-level model.
module tb_keypad_scan_reader;
  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FD = 4;
  localparam logic [31:0] BASE = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic        mem_la_read = 1'b0;
  logic [31:0] mem_la_addr = 32'h0;
  logic [31:0] rdata;
  logic        rdata_sel;
`ifdef KEYPAD_IRQ_EN
  logic        irq;
`endif
  logic [15:0] key_mask = 16'h0;
  int errors = 0;
  int checks = 0;

  keypad_scan_reader #(.SCAN_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(FD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .key_col(key_col), .key_row(key_row),
    .mem_la_read(mem_la_read), .mem_la_addr(mem_la_addr),
    .rdata(rdata), .rdata_sel(rdata_sel)
`ifdef KEYPAD_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its row line onto its column line.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && key_mask[r*4+c]) key_col[c] = 1'b0;
  end

  // Behavioural model state: queue of accepted codes, sticky overflow, debounce run length.
  int          q[$];
  bit          m_ovf, m_down;
  int          m_run, m_code;
  logic [31:0] m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_down = 1'b0; m_run = 0; m_code = 0; m_last = 32'h0;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = {28'h0, 4'(q.size())};
    if (m_ovf)          s = s | 32'h0000_8000;
    if (q.size() == 0)  s = s | 32'h0000_0020;
    if (q.size() == FD) s = s | 32'h0000_0010;
    return s;
  endfunction

  task automatic model_read(input int kind, output logic [31:0] ed, output logic es);
    if (kind == 1) begin
      ed = model_status(); es = 1'b1; m_ovf = 1'b0; m_last = ed;
    end else if (kind == 2) begin
      if (q.size() == 0) ed = 32'h0;
      else begin
        ed = {1'b1, 27'h0, 4'(q[0])};
        void'(q.pop_front());
      end
      es = 1'b1; m_last = ed;
    end else begin
      ed = m_last; es = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [15:0] mask);
    bit hit;
    int code;
    hit = (mask != 16'h0);
    code = -1;
    for (int i = 0; i < 16; i++) if (mask[i] && code < 0) code = i;
    if (!m_down) begin
      if (!hit)               m_run = 0;
      else if (m_run == 0)    begin m_code = code; m_run = 1; end
      else if (code == m_code) m_run++;
      else                    m_run = 0;
      if (m_run == DB) begin
        m_down = 1'b1; m_run = 0;
        if (q.size() == FD) m_ovf = 1'b1;
        else q.push_back(code);
      end
    end else begin
      if (hit) m_run = 0;
      else     m_run++;
      if (m_run == DB) begin m_down = 1'b0; m_run = 0; end
    end
  endtask

  function automatic logic [31:0] addr_of(input int kind);
    logic [31:0] others [4];
    others[0] = 32'h1000_0000; others[1] = 32'h1000_000C;
    others[2] = 32'h1000_0005; others[3] = 32'h0000_0004;
    if (kind == 1) return BASE;
    if (kind == 2) return BASE + 32'd4;
    return others[$urandom_range(0, 3)];
  endfunction

  // One scan frame (16 cycles) starting at the negedge of its first cycle; optional read at cycle pos.
  task automatic run_frame(input logic [15:0] mask, input int kind, input int pos,
                           output logic [31:0] got_d, output logic got_s);
    logic [31:0] ed;
    logic        es;
    logic [3:0]  er;
    got_d = 32'h0; got_s = 1'b0; ed = 32'h0; es = 1'b0;
    key_mask = mask;
    for (int i = 0; i < 16; i++) begin
      er = ~(4'b0001 << (i / 4));
      chk("key_row", {28'h0, key_row}, {28'h0, er});
      if (kind != 0 && i == pos) begin
        mem_la_read = 1'b1;
        mem_la_addr = addr_of(kind);
        model_read(kind, ed, es);
      end
      @(negedge clk);
      if (kind != 0 && i == pos) begin
        mem_la_read = 1'b0;
        got_d = rdata; got_s = rdata_sel;
        chk("model_sel", {31'h0, rdata_sel}, {31'h0, es});
        chk("model_rdata", rdata, ed);
      end
    end
    model_frame(mask);
  endtask

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          rd;
    int          pos;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] gd;
  logic        gs;
  logic [15:0] rmask;

  task automatic press(input logic [15:0] m);
    tbl.push_back('{m, 2, 0, 0, 32'h0});
    tbl.push_back('{16'h0000, 2, 0, 0, 32'h0});
  endtask

  initial begin
    // reset state
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_key_row", {28'h0, key_row}, 32'h0000_000E);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_sel", {31'h0, rdata_sel}, 32'h0);
    reset = 1'b0;

    // held key, single push, then empty DATA
    tbl.push_back('{16'h0200, 5, 0, 0, 32'h0});
    tbl.push_back('{16'h0000, 2, 0, 0, 32'h0});
    tbl.push_back('{16'h0000, 1, 2, 5, 32'h8000_0009});
    tbl.push_back('{16'h0000, 1, 2, 5, 32'h0000_0000});
    // one-frame bounce
    tbl.push_back('{16'h0008, 1, 0, 0, 32'h0});
    tbl.push_back('{16'h0000, 1, 1, 5, 32'h0000_0020});
    // five presses overflow a 4-deep FIFO; lowest key wins on multi-press
    press(16'h0001); press(16'h1020); press(16'h0400); press(16'h8000); press(16'h0040);
    tbl.push_back('{16'h0000, 1, 1, 5, 32'h0000_8014});
    tbl.push_back('{16'h0000, 1, 1, 5, 32'h0000_0014});
    tbl.push_back('{16'h0000, 1, 2, 3, 32'h8000_0000});
    tbl.push_back('{16'h0000, 1, 2, 3, 32'h8000_0005});
    tbl.push_back('{16'h0000, 1, 2, 3, 32'h8000_000A});
    tbl.push_back('{16'h0000, 1, 2, 3, 32'h8000_000F});
    tbl.push_back('{16'h0000, 1, 1, 3, 32'h0000_0020});
    // pop in the same cycle a push lands on a full FIFO
    press(16'h0002); press(16'h0004); press(16'h0010); press(16'h0100);
    tbl.push_back('{16'h0080, 1, 0, 0, 32'h0});
    tbl.push_back('{16'h0080, 1, 2, 15, 32'h8000_0001});
    tbl.push_back('{16'h0000, 2, 1, 5, 32'h0000_0014});
    tbl.push_back('{16'h0000, 1, 2, 7, 32'h8000_0002});
    tbl.push_back('{16'h0000, 1, 2, 7, 32'h8000_0004});
    tbl.push_back('{16'h0000, 1, 2, 7, 32'h8000_0008});
    tbl.push_back('{16'h0000, 1, 2, 7, 32'h8000_0007});
    tbl.push_back('{16'h0000, 1, 1, 7, 32'h0000_0020});
    tbl.push_back('{16'h0000, 1, 3, 9, 32'h0000_0020});

    foreach (tbl[k]) begin
      for (int f = 0; f < tbl[k].frames; f++) begin
        if (f == tbl[k].frames - 1 && tbl[k].rd != 0) begin
          run_frame(tbl[k].mask, tbl[k].rd, tbl[k].pos, gd, gs);
          chk($sformatf("vec%0d_sel", k), {31'h0, gs}, {31'h0, (tbl[k].rd != 3)});
          chk($sformatf("vec%0d_rdata", k), gd, tbl[k].exp);
        end else begin
          run_frame(tbl[k].mask, 0, 0, gd, gs);
        end
      end
    end

    // reset mid-CONFIRM with two entries queued
    run_frame(16'h0800, 0, 0, gd, gs); run_frame(16'h0800, 0, 0, gd, gs);
    run_frame(16'h0000, 0, 0, gd, gs); run_frame(16'h0000, 0, 0, gd, gs);
    run_frame(16'h1000, 0, 0, gd, gs); run_frame(16'h1000, 0, 0, gd, gs);
    run_frame(16'h0000, 0, 0, gd, gs); run_frame(16'h0000, 0, 0, gd, gs);
    run_frame(16'h4000, 0, 0, gd, gs);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    key_mask = 16'h0;
    #1;
    chk("midrst_key_row", {28'h0, key_row}, 32'h0000_000E);
    chk("midrst_sel", {31'h0, rdata_sel}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_frame(16'h0000, 1, 5, gd, gs);
    chk("midrst_status", gd, 32'h0000_0020);

`ifdef KEYPAD_IRQ_EN
    // irq follows FIFO occupancy one cycle late
    run_frame(16'h0200, 0, 0, gd, gs);
    run_frame(16'h0200, 0, 0, gd, gs);
    key_mask = 16'h0200;
    chk("irq_before", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    mem_la_read = 1'b1; mem_la_addr = BASE + 32'd4;
    model_read(2, gd, gs);
    @(negedge clk);
    mem_la_read = 1'b0;
    chk("irq_pop_data", rdata, 32'h8000_0009);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_fall", {31'h0, irq}, 32'h0);
    repeat (13) @(negedge clk);
    model_frame(16'h0200);
    run_frame(16'h0000, 0, 0, gd, gs);
    run_frame(16'h0000, 0, 0, gd, gs);
`endif

    // randomized frames against the model
    rmask = 16'h0;
    for (int n = 0; n < 120; n++) begin
      int r, kind;
      r = $urandom_range(0, 9);
      if (r < 4)      rmask = rmask;
      else if (r < 7) rmask = 16'h0;
      else if (r < 9) rmask = 16'h0001 << $urandom_range(0, 15);
      else            rmask = 16'($urandom_range(0, 65535) & $urandom_range(0, 65535));
      kind = $urandom_range(0, 5);
      if (kind > 3) kind = 0;
      run_frame(rmask, kind, $urandom_range(0, 15), gd, gs);
    end
    run_frame(16'h0000, 1, 4, gd, gs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
